// File: rtl/song_player_ctrl_pkg.sv
// Shared definitions for the song player transport controller.
// Holds the state encoding and default widths used by the interface and RTL.
package song_pkg;

  localparam int unsigned IDX_W_DEF  = 8;
  localparam int unsigned TICK_W_DEF = 24;
  localparam int unsigned TONE_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/song_player_ctrl_if.sv
// Control/status bundle between user controls and the song player controller.
// The master side drives transport commands; the slave side is the controller.
interface song_player_ctrl_if
  import song_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned TICK_W = TICK_W_DEF
);

  logic              play;
  logic              pause;
  logic              stop;
  logic              loop_en;
  logic [TICK_W-1:0] tempo_ticks;
  logic [IDX_W-1:0]  song_len;
  logic [IDX_W-1:0]  note_index;
  logic              step_strobe;
  logic              tone_en;
  logic              playing;
  logic              done;

  modport master (
    output play, pause, stop, loop_en, tempo_ticks, song_len,
    input  note_index, step_strobe, tone_en, playing, done
  );

  modport slave (
    input  play, pause, stop, loop_en, tempo_ticks, song_len,
    output note_index, step_strobe, tone_en, playing, done
  );

endinterface

// File: rtl/song_player_ctrl_tempo_divider.sv
// Tempo counter: counts enabled cycles and flags the last cycle of each step period.
// A period of 0 is stored as 1 so the terminal count is always reachable.
module tempo_divider #(
  parameter int unsigned TICK_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              load,
  input  logic [TICK_W-1:0] tempo,
  output logic              terminal
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] period_q;

  assign terminal = (cnt_q == period_q - TICK_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= TICK_W'(1);
    end else begin
      if (clear) begin
        cnt_q <= '0;
      end else if (enable) begin
        cnt_q <= terminal ? '0 : cnt_q + TICK_W'(1);
      end
      if (load) begin
        period_q <= (tempo == '0) ? TICK_W'(1) : tempo;
      end
    end
  end

endmodule

// File: rtl/song_player_ctrl.sv
// Transport/tempo controller: steps the song ROM index at a programmable tempo with
// play/pause/stop, loop-or-end at song length, and a tone mute gate.
module song_player_ctrl
  import song_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned TICK_W = TICK_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  song_player_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;

  logic             start;
  logic             step;
  logic             div_clear;
  logic             div_enable;
  logic             terminal;
  logic [IDX_W-1:0] last_idx;
  logic             is_last;

  // song_len of 0 wraps to all-ones, i.e. the full 2**IDX_W range.
  assign last_idx = bus.song_len - IDX_W'(1);
  assign is_last  = (idx_q >= last_idx);

  tempo_divider #(
    .TICK_W (TICK_W)
  ) u_tempo_divider (
    .clk      (clk),
    .reset    (reset),
    .clear    (div_clear),
    .enable   (div_enable),
    .load     (start | step),
    .tempo    (bus.tempo_ticks),
    .terminal (terminal)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    start      = 1'b0;
    step       = 1'b0;
    div_clear  = 1'b0;
    div_enable = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.play) begin
          state_d   = ST_PLAY;
          start     = 1'b1;
          div_clear = 1'b1;
          idx_d     = '0;
        end
      end
      ST_PLAY: begin
        if (bus.stop) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          div_clear = 1'b1;
        end else if (bus.pause) begin
          // A pause landing on the terminal cycle freezes the count so the step is not lost.
          state_d    = ST_PAUSE;
          div_enable = ~terminal;
        end else begin
          div_enable = 1'b1;
          if (terminal) begin
            step = 1'b1;
            if (is_last) begin
              idx_d = '0;
              if (bus.loop_en) begin
                strobe_d = 1'b1;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              idx_d    = idx_q + IDX_W'(1);
              strobe_d = 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          div_clear = 1'b1;
        end else if (bus.play) begin
          state_d = ST_PLAY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign bus.note_index  = idx_q;
  assign bus.step_strobe = strobe_q;
  assign bus.done        = done_q;
  assign bus.tone_en     = (state_q == ST_PLAY);
  assign bus.playing     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_song_player_ctrl.sv
// Directed bench for song_player_ctrl; cycle c is the period after the c-th rising edge
// following a play pulse, and outputs are compared at each falling edge.
module tb_song_player_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;

  song_player_ctrl_if #(.IDX_W(8), .TICK_W(24)) bus ();

  song_player_ctrl #(
    .IDX_W  (8),
    .TICK_W (24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] pk(input int idx, input logic s, input logic t,
                                     input logic p, input logic d);
    logic [7:0] i8;
    i8 = idx[7:0];
    return {20'd0, i8, s, t, p, d};
  endfunction

  function automatic logic [31:0] obs();
    return pk(int'(bus.note_index), bus.step_strobe, bus.tone_en, bus.playing, bus.done);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got idx=%0d s/t/p/d=%b required idx=%0d s/t/p/d=%b",
               tag, cyc, got[11:4], got[3:0], exp[11:4], exp[3:0]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic pulse_play();
    cyc = 0;
    bus.play = 1'b1;
    tick();
    bus.play = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.play        = 1'b0;
    bus.pause       = 1'b0;
    bus.stop        = 1'b0;
    bus.loop_en     = 1'b0;
    bus.tempo_ticks = 24'd4;
    bus.song_len    = 8'd4;
    repeat (3) tick();
    check_eq("reset", obs(), pk(0, 0, 0, 0, 0));
    reset = 1'b0;
    tick();
    check_eq("idle", obs(), pk(0, 0, 0, 0, 0));

    // 1: tempo 4, len 4, no loop
    pulse_play();
    for (int c = 1; c <= 18; c++) begin
      if (c <= 16) check_eq("t1_run", obs(), pk((c - 1) / 4, (c == 5 || c == 9 || c == 13), 1, 1, 0));
      else if (c == 17) check_eq("t1_done", obs(), pk(0, 0, 0, 0, 1));
      else check_eq("t1_after", obs(), pk(0, 0, 0, 0, 0));
      tick();
    end

    // 2: same with loop
    bus.loop_en = 1'b1;
    pulse_play();
    for (int c = 1; c <= 40; c++) begin
      check_eq("t2_loop", obs(), pk(((c - 1) / 4) % 4, (c > 1 && (c - 1) % 4 == 0), 1, 1, 0));
      tick();
    end
    do_stop();
    check_eq("t2_stop", obs(), pk(0, 0, 0, 0, 0));

    // 3: pause in 2nd cycle of index 2
    bus.loop_en  = 1'b0;
    bus.song_len = 8'd8;
    pulse_play();
    while (cyc < 10) tick();
    check_eq("t3_pre", obs(), pk(2, 0, 1, 1, 0));
    bus.pause = 1'b1;
    tick();
    bus.pause = 1'b0;
    for (int c = 11; c <= 20; c++) begin
      check_eq("t3_paused", obs(), pk(2, 0, 0, 1, 0));
      if (c == 20) bus.play = 1'b1;
      tick();
    end
    bus.play = 1'b0;
    check_eq("t3_res1", obs(), pk(2, 0, 1, 1, 0));
    tick();
    check_eq("t3_res2", obs(), pk(2, 0, 1, 1, 0));
    tick();
    check_eq("t3_next", obs(), pk(3, 1, 1, 1, 0));
    do_stop();

    // 4: stop on a step cycle, then all commands at once
    pulse_play();
    while (cyc < 4) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_eq("t4_stopstep", obs(), pk(0, 0, 0, 0, 0));
    tick();
    check_eq("t4_quiet", obs(), pk(0, 0, 0, 0, 0));
    pulse_play();
    tick();
    check_eq("t4_play", obs(), pk(0, 0, 1, 1, 0));
    bus.play  = 1'b1;
    bus.pause = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.play  = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    check_eq("t4_all", obs(), pk(0, 0, 0, 0, 0));
    tick();

    // 5a: tempo 0 steps every cycle
    bus.tempo_ticks = 24'd0;
    bus.loop_en     = 1'b1;
    pulse_play();
    for (int c = 1; c <= 12; c++) begin
      check_eq("t5_t0", obs(), pk((c - 1) % 8, c >= 2, 1, 1, 0));
      tick();
    end
    do_stop();

    // 5b: tempo 4 -> 8 mid-step
    bus.tempo_ticks = 24'd4;
    bus.loop_en     = 1'b0;
    pulse_play();
    for (int c = 1; c <= 14; c++) begin
      check_eq("t5_tempo", obs(), pk((c < 5) ? 0 : (c < 13) ? 1 : 2, (c == 5 || c == 13), 1, 1, 0));
      if (c == 2) bus.tempo_ticks = 24'd8;
      tick();
    end
    do_stop();

    // 5c: full-range song, loop then no loop
    bus.tempo_ticks = 24'd1;
    bus.song_len    = 8'd0;
    bus.loop_en     = 1'b1;
    pulse_play();
    for (int c = 1; c <= 258; c++) begin
      check_eq("t5_wrap", obs(), pk((c - 1) % 256, c >= 2, 1, 1, 0));
      tick();
    end
    do_stop();
    bus.loop_en = 1'b0;
    pulse_play();
    for (int c = 1; c <= 257; c++) begin
      if (c <= 256) check_eq("t5_full", obs(), pk(c - 1, c >= 2, 1, 1, 0));
      else check_eq("t5_fulldone", obs(), pk(0, 0, 0, 0, 1));
      tick();
    end

    // song_len reduced below current index ends at next step
    bus.song_len = 8'd16;
    pulse_play();
    for (int c = 1; c <= 6; c++) begin
      check_eq("tl_run", obs(), pk(c - 1, c >= 2, 1, 1, 0));
      if (c == 6) bus.song_len = 8'd4;
      tick();
    end
    check_eq("tl_done", obs(), pk(0, 0, 0, 0, 1));
    tick();

    // 6: reset mid-play at index 5
    bus.tempo_ticks = 24'd2;
    bus.song_len    = 8'd16;
    pulse_play();
    while (cyc < 11) tick();
    check_eq("t6_idx5", obs(), pk(5, 1, 1, 1, 0));
    reset    = 1'b1;
    bus.play = 1'b1;
    tick();
    check_eq("t6_rst1", obs(), pk(0, 0, 0, 0, 0));
    tick();
    check_eq("t6_rst2", obs(), pk(0, 0, 0, 0, 0));
    reset    = 1'b0;
    bus.play = 1'b0;
    tick();
    check_eq("t6_post", obs(), pk(0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
